mem_line_responder: RTL and testbench
=====================================

Name: mem_line_responder

Overview:
- Memory-side responder for the cache line command interface.
- Accepts one line-fill (load) or line-writeback (store) command at a time from a single cache. Splits the line into 2**OFFSET_LENGTH word beats on a word-serial backing-memory port, then reassembles or retires them.
- Completes each command with a one-cycle bus_valid (fill) or bus_ready (writeback) pulse.
- Optionally broadcasts a one-cycle snoop invalidate for each retired store to the other caches.

Parameters:
- ADDR_WIDTH, 64, word-address width on both ports.
- DATA_WIDTH, 64, word width.
- OFFSET_LENGTH, 4, log2 of words per line; LINE_W = DATA_WIDTH*2**OFFSET_LENGTH.
- INVAL_ON_STORE, 1, when 1, pulse inval on writeback completion.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- command_valid  in  1  cache command present; held until completion pulse.
- command_store  in  1  1 = writeback, 0 = fill.
- command_rready  in  1  cache ready to take fill data; fills require it.
- command_addr  in  ADDR_WIDTH  line word address; low OFFSET_LENGTH bits ignored (treated as 0).
- data_to_bus  in  LINE_W  writeback line; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- data_from_bus  out  LINE_W  assembled fill line, same packing.
- bus_valid  out  1  one-cycle fill-complete pulse.
- bus_ready  out  1  one-cycle writeback-complete pulse.
- mem_req  out  1  backing-memory beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_WIDTH  beat word address.
- mem_wdata  out  DATA_WIDTH  write beat data.
- mem_gnt  in  1  beat accepted this cycle (mem_req & mem_gnt).
- mem_rvalid  in  1  read data beat returning; in order, any latency ≥1 cycle after gnt.
- mem_rdata  in  DATA_WIDTH  read data.
- inval  out  1  snoop invalidate pulse.
- inval_addr  out  ADDR_WIDTH  line address being invalidated (offset bits 0).

Behaviour:
- Reset: all outputs 0. data_from_bus, counters and the captured line/address registers clear. State returns to IDLE. A reset mid-command aborts it with no completion pulse. mem_rvalid beats arriving after reset are discarded.
- Command acceptance:
  - The command is sampled in IDLE only.
  - Fill starts when command_valid & !command_store & command_rready.
  - Writeback starts when command_valid & command_store.
  - On acceptance, capture line_addr = {command_addr[ADDR_WIDTH-1:OFFSET_LENGTH], 0}. For a writeback, also capture data_to_bus.
  - command_* changes after acceptance are ignored until the pulse.
- States: IDLE, RD_ISSUE, RD_DRAIN, WR_ISSUE, DONE.
- RD_ISSUE:
  - mem_req=1, mem_we=0, mem_addr = line_addr + issue_cnt.
  - issue_cnt increments on gnt.
  - After the last beat is granted, go to RD_DRAIN, or to DONE if all beats have already returned.
- Read return (both RD states):
  - Each mem_rvalid writes mem_rdata into word ret_cnt of the line buffer, then ret_cnt increments.
  - rvalid and gnt in the same cycle are both handled.
- RD_DRAIN: mem_req=0. When ret_cnt wraps to 0 after the last beat, go to DONE.
- WR_ISSUE:
  - mem_req=1, mem_we=1, mem_addr = line_addr + issue_cnt, mem_wdata = captured word issue_cnt.
  - After the last beat is granted, go to DONE.
- DONE (exactly one cycle):
  - Fill: bus_valid=1; data_from_bus holds the line, stable until the next fill completes.
  - Writeback: bus_ready=1. If INVAL_ON_STORE, also inval=1 and inval_addr=line_addr in the same cycle.
  - Then return to IDLE.
  - A new command visible in the cycle after DONE is accepted immediately (back-to-back fill→writeback supported).
- Counters: OFFSET_LENGTH bits, wrap naturally; the last beat is count == all-ones. Address addition is modulo 2**ADDR_WIDTH.
- mem_req stays asserted with stable addr/data/we until gnt (no retraction).
- Latency: a fill with zero-wait gnt and 1-cycle rvalid completes in 2**OFFSET_LENGTH+2 cycles from acceptance. A writeback with always-gnt completes in 2**OFFSET_LENGTH+1 cycles.
- Stray mem_rvalid in IDLE, WR_ISSUE or DONE: ignored, no state change.
- A fill command with command_rready=0 waits in IDLE.

Test Plan:
- Fill: reset, command_addr=0x1234 load, mem returns word k = 0xA000+k with gnt always 1 and 1-cycle latency → mem_addr 0x1230..0x123F in order. bus_valid pulses once at cycle 18 after acceptance; data_from_bus word k = 0xA000+k.
- Writeback with stalls: store to 0x40, data word k = k, gnt toggling 1/0 → 16 writes to 0x40..0x4F with data 0..15, addr/data held during stalls. bus_ready pulses once; inval=1 with inval_addr=0x40 in the same cycle.
- Back-to-back: fill 0x100, and in the cycle after bus_valid present store 0x200 → store accepted with no idle gap; bus_ready follows; no second bus_valid.
- Out-of-phase returns: gnt on every cycle, rvalid delayed 5 cycles → RD_DRAIN entered, ret_cnt completes, line correct, single pulse.
- Reset mid-fill after 7 beats, rvalid still arriving → outputs 0 next cycle, no pulse. A subsequent fill of 0x300 returns only the new data.
- INVAL_ON_STORE=0: writeback → bus_ready pulses, inval stays 0. Load with command_rready=0 for 3 cycles → no mem_req until command_rready rises.

Source files
------------

// File: rtl/mem_line_responder_if.sv
// Bundle of the cache command port and the word-serial backing-memory port
// served by mem_line_responder.
interface mem_line_responder_if #(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int OFFSET_LENGTH = 4
);
    localparam int LINE_W = DATA_WIDTH * (2 ** OFFSET_LENGTH);

    logic                  command_valid;
    logic                  command_store;
    logic                  command_rready;
    logic [ADDR_WIDTH-1:0] command_addr;
    logic [LINE_W-1:0]     data_to_bus;
    logic [LINE_W-1:0]     data_from_bus;
    logic                  bus_valid;
    logic                  bus_ready;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  inval;
    logic [ADDR_WIDTH-1:0] inval_addr;

    // Responder side
    modport slave (
        input  command_valid, command_store, command_rready, command_addr, data_to_bus,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output data_from_bus, bus_valid, bus_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, inval, inval_addr
    );

    // Cache plus backing-memory side
    modport master (
        output command_valid, command_store, command_rready, command_addr, data_to_bus,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  data_from_bus, bus_valid, bus_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, inval, inval_addr
    );
endinterface

// File: rtl/mem_line_responder.sv
// Memory-side line responder: splits one fill/writeback command into word
// beats on the backing-memory port and signals completion with a single pulse.
module mem_line_responder #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int OFFSET_LENGTH  = 4,
    parameter bit INVAL_ON_STORE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_line_responder_if.slave   bus
);
    localparam int LINE_W = DATA_WIDTH * (2 ** OFFSET_LENGTH);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t                   r_state, w_state_next;
    logic [OFFSET_LENGTH-1:0] r_issue_cnt, w_issue_cnt_next;
    logic [OFFSET_LENGTH-1:0] r_ret_cnt, w_ret_cnt_next;
    logic [ADDR_WIDTH-1:0]    r_line_addr, w_line_addr_next;
    logic                     r_is_store, w_is_store_next;
    logic [LINE_W-1:0]        r_wr_line, w_wr_line_next;
    logic [LINE_W-1:0]        r_fill_buf, w_fill_buf_next;

    logic [LINE_W-1:0]        r_data_from_bus, w_data_from_bus_next;
    logic                     r_bus_valid, w_bus_valid_next;
    logic                     r_bus_ready, w_bus_ready_next;
    logic                     r_mem_req, w_mem_req_next;
    logic                     r_mem_we, w_mem_we_next;
    logic [ADDR_WIDTH-1:0]    r_mem_addr, w_mem_addr_next;
    logic [DATA_WIDTH-1:0]    r_mem_wdata, w_mem_wdata_next;
    logic                     r_inval, w_inval_next;
    logic [ADDR_WIDTH-1:0]    r_inval_addr, w_inval_addr_next;

    logic w_accept_rd, w_accept_wr, w_issue_fire, w_ret_fire, w_issue_last, w_ret_last;
    logic w_unused_offset;

    assign w_unused_offset = ^bus.command_addr[OFFSET_LENGTH-1:0];

    assign w_accept_rd  = (r_state == ST_IDLE) & bus.command_valid & ~bus.command_store & bus.command_rready;
    assign w_accept_wr  = (r_state == ST_IDLE) & bus.command_valid & bus.command_store;
    assign w_issue_fire = ((r_state == ST_RD_ISSUE) | (r_state == ST_WR_ISSUE)) & bus.mem_gnt;
    assign w_ret_fire   = ((r_state == ST_RD_ISSUE) | (r_state == ST_RD_DRAIN)) & bus.mem_rvalid;
    assign w_issue_last = (r_issue_cnt == {OFFSET_LENGTH{1'b1}});
    assign w_ret_last   = (r_ret_cnt == {OFFSET_LENGTH{1'b1}});

    // State register and captured command / beat counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_issue_cnt <= {OFFSET_LENGTH{1'b0}};
            r_ret_cnt   <= {OFFSET_LENGTH{1'b0}};
            r_line_addr <= {ADDR_WIDTH{1'b0}};
            r_is_store  <= 1'b0;
            r_wr_line   <= {LINE_W{1'b0}};
            r_fill_buf  <= {LINE_W{1'b0}};
        end else begin
            r_state     <= w_state_next;
            r_issue_cnt <= w_issue_cnt_next;
            r_ret_cnt   <= w_ret_cnt_next;
            r_line_addr <= w_line_addr_next;
            r_is_store  <= w_is_store_next;
            r_wr_line   <= w_wr_line_next;
            r_fill_buf  <= w_fill_buf_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept_wr) begin
                    w_state_next = ST_WR_ISSUE;
                end else if (w_accept_rd) begin
                    w_state_next = ST_RD_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                if (w_issue_fire && w_issue_last) begin
                    w_state_next = (w_ret_fire && w_ret_last) ? ST_DONE : ST_RD_DRAIN;
                end else begin
                    w_state_next = ST_RD_ISSUE;
                end
            end
            ST_RD_DRAIN: begin
                if (w_ret_fire && w_ret_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RD_DRAIN;
                end
            end
            ST_WR_ISSUE: begin
                if (w_issue_fire && w_issue_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_WR_ISSUE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Command capture, beat counting and fill-line assembly
    always_comb begin
        w_issue_cnt_next = r_issue_cnt;
        w_ret_cnt_next   = r_ret_cnt;
        w_line_addr_next = r_line_addr;
        w_is_store_next  = r_is_store;
        w_wr_line_next   = r_wr_line;
        w_fill_buf_next  = r_fill_buf;
        if (w_accept_rd || w_accept_wr) begin
            w_line_addr_next = {bus.command_addr[ADDR_WIDTH-1:OFFSET_LENGTH], {OFFSET_LENGTH{1'b0}}};
            w_is_store_next  = w_accept_wr;
            w_issue_cnt_next = {OFFSET_LENGTH{1'b0}};
            w_ret_cnt_next   = {OFFSET_LENGTH{1'b0}};
            w_wr_line_next   = w_accept_wr ? bus.data_to_bus : r_wr_line;
        end else begin
            w_line_addr_next = r_line_addr;
        end
        if (w_issue_fire) begin
            w_issue_cnt_next = r_issue_cnt + {{(OFFSET_LENGTH-1){1'b0}}, 1'b1};
        end else begin
            w_issue_cnt_next = w_issue_cnt_next;
        end
        // A return and a grant in the same cycle touch independent counters
        if (w_ret_fire) begin
            w_ret_cnt_next = r_ret_cnt + {{(OFFSET_LENGTH-1){1'b0}}, 1'b1};
            w_fill_buf_next[DATA_WIDTH*int'(r_ret_cnt) +: DATA_WIDTH] = bus.mem_rdata;
        end else begin
            w_ret_cnt_next = w_ret_cnt_next;
        end
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        w_mem_req_next       = 1'b0;
        w_mem_we_next        = 1'b0;
        w_mem_addr_next      = {ADDR_WIDTH{1'b0}};
        w_mem_wdata_next     = {DATA_WIDTH{1'b0}};
        w_bus_valid_next     = 1'b0;
        w_bus_ready_next     = 1'b0;
        w_inval_next         = 1'b0;
        w_inval_addr_next    = {ADDR_WIDTH{1'b0}};
        w_data_from_bus_next = r_data_from_bus;
        case (w_state_next)
            ST_RD_ISSUE: begin
                w_mem_req_next  = 1'b1;
                w_mem_addr_next = w_line_addr_next
                                + {{(ADDR_WIDTH-OFFSET_LENGTH){1'b0}}, w_issue_cnt_next};
            end
            ST_WR_ISSUE: begin
                w_mem_req_next   = 1'b1;
                w_mem_we_next    = 1'b1;
                w_mem_addr_next  = w_line_addr_next
                                 + {{(ADDR_WIDTH-OFFSET_LENGTH){1'b0}}, w_issue_cnt_next};
                w_mem_wdata_next = w_wr_line_next[DATA_WIDTH*int'(w_issue_cnt_next) +: DATA_WIDTH];
            end
            ST_DONE: begin
                if (w_is_store_next) begin
                    w_bus_ready_next  = 1'b1;
                    w_inval_next      = INVAL_ON_STORE;
                    w_inval_addr_next = INVAL_ON_STORE ? w_line_addr_next : {ADDR_WIDTH{1'b0}};
                end else begin
                    w_bus_valid_next     = 1'b1;
                    w_data_from_bus_next = w_fill_buf_next;
                end
            end
            default: begin
                w_mem_req_next = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_from_bus <= {LINE_W{1'b0}};
            r_bus_valid     <= 1'b0;
            r_bus_ready     <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= {ADDR_WIDTH{1'b0}};
            r_mem_wdata     <= {DATA_WIDTH{1'b0}};
            r_inval         <= 1'b0;
            r_inval_addr    <= {ADDR_WIDTH{1'b0}};
        end else begin
            r_data_from_bus <= w_data_from_bus_next;
            r_bus_valid     <= w_bus_valid_next;
            r_bus_ready     <= w_bus_ready_next;
            r_mem_req       <= w_mem_req_next;
            r_mem_we        <= w_mem_we_next;
            r_mem_addr      <= w_mem_addr_next;
            r_mem_wdata     <= w_mem_wdata_next;
            r_inval         <= w_inval_next;
            r_inval_addr    <= w_inval_addr_next;
        end
    end

    assign bus.data_from_bus = r_data_from_bus;
    assign bus.bus_valid     = r_bus_valid;
    assign bus.bus_ready     = r_bus_ready;
    assign bus.mem_req       = r_mem_req;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.inval         = r_inval;
    assign bus.inval_addr    = r_inval_addr;
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: one instance with store-invalidate,
// one without, each served by a small backing-memory model.
module tb_mem_line_responder;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int OL = 4;
    localparam int NW = 16;
    localparam int LW = DW * NW;

    typedef struct {
        int          due;
        logic [63:0] data;
    } ret_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_line_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_LENGTH(OL)) b0 ();
    mem_line_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_LENGTH(OL)) b1 ();

    mem_line_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_LENGTH(OL),
                         .INVAL_ON_STORE(1'b1)) u_dut (.clk(clk), .reset(reset), .bus(b0));
    mem_line_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_LENGTH(OL),
                         .INVAL_ON_STORE(1'b0)) u_dut_ni (.clk(clk), .reset(reset), .bus(b1));

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          gnt_mode = 0;
    int          lat      = 1;
    logic [63:0] rd_base  = 64'd0;
    ret_t        ret_q[$];
    ret_t        ret1_q[$];
    logic [63:0] rd_log[$];
    logic [63:0] wr_addr_log[$];
    logic [63:0] wr_data_log[$];
    int          hold_err   = 0;
    int          bv_cnt     = 0;
    int          br_cnt     = 0;
    int          inv_cnt    = 0;
    int          ni_inv_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk_line(input logic [63:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < NW; k++) l[k*DW +: DW] = base + 64'(k);
        return l;
    endfunction

    function automatic int line_bad(input logic [LW-1:0] got, input logic [63:0] base);
        int n = 0;
        for (int k = 0; k < NW; k++) if (got[k*DW +: DW] !== base + 64'(k)) n++;
        return n;
    endfunction

    // Waits for a completion pulse; sel 0/1 = b0 valid/ready, 2/3 = b1 valid/ready
    task automatic wait_pulse(input int sel, input int limit, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = b0.bus_valid;
                1:       hit = b0.bus_ready;
                2:       hit = b1.bus_valid;
                default: hit = b1.bus_ready;
            endcase
            if (hit) begin
                at = cyc;
                break;
            end
        end
        check_eq("pulse_seen", 64'(at >= 0), 64'd1);
    endtask

    // Backing memory for b0: configurable grant pattern and read latency
    initial begin
        logic        p_req;
        logic [63:0] p_addr, p_data;
        logic        p_we;
        ret_t        r;
        p_req = 1'b0; p_addr = 64'd0; p_data = 64'd0; p_we = 1'b0;
        b0.mem_gnt = 1'b0; b0.mem_rvalid = 1'b0; b0.mem_rdata = 64'd0;
        forever begin
            @(negedge clk);
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                b0.mem_rvalid = 1'b1;
                b0.mem_rdata  = ret_q[0].data;
                void'(ret_q.pop_front());
            end else begin
                b0.mem_rvalid = 1'b0;
                b0.mem_rdata  = 64'd0;
            end
            if (p_req && b0.mem_req &&
                ({b0.mem_addr, b0.mem_wdata, b0.mem_we} !== {p_addr, p_data, p_we})) hold_err++;
            b0.mem_gnt = b0.mem_req && (gnt_mode == 0 || (cyc % 2) == 0);
            p_req  = b0.mem_req && !b0.mem_gnt;
            p_addr = b0.mem_addr; p_data = b0.mem_wdata; p_we = b0.mem_we;
            if (b0.mem_gnt && b0.mem_we) begin
                wr_addr_log.push_back(b0.mem_addr);
                wr_data_log.push_back(b0.mem_wdata);
            end else if (b0.mem_gnt) begin
                rd_log.push_back(b0.mem_addr);
                r.due  = cyc + lat;
                r.data = rd_base + {60'd0, b0.mem_addr[3:0]};
                ret_q.push_back(r);
            end
            if (b0.bus_valid) bv_cnt++;
            if (b0.bus_ready) br_cnt++;
            if (b0.inval) inv_cnt++;
        end
    end

    // Backing memory for b1: always grants, one-cycle read latency
    initial begin
        ret_t r;
        b1.mem_gnt = 1'b0; b1.mem_rvalid = 1'b0; b1.mem_rdata = 64'd0;
        forever begin
            @(negedge clk);
            if (ret1_q.size() > 0 && ret1_q[0].due <= cyc) begin
                b1.mem_rvalid = 1'b1;
                b1.mem_rdata  = ret1_q[0].data;
                void'(ret1_q.pop_front());
            end else begin
                b1.mem_rvalid = 1'b0;
                b1.mem_rdata  = 64'd0;
            end
            b1.mem_gnt = b1.mem_req;
            if (b1.mem_gnt && !b1.mem_we) begin
                r.due  = cyc + 1;
                r.data = 64'hF000 + {60'd0, b1.mem_addr[3:0]};
                ret1_q.push_back(r);
            end
            if (b1.inval) ni_inv_cnt++;
        end
    end

    initial begin
        int a, at, bv0, br0, inv0, rd0, wr0, h0, errs;
        b0.command_valid = 1'b0; b0.command_store = 1'b0; b0.command_rready = 1'b0;
        b0.command_addr = 64'd0; b0.data_to_bus = '0;
        b1.command_valid = 1'b0; b1.command_store = 1'b0; b1.command_rready = 1'b0;
        b1.command_addr = 64'd0; b1.data_to_bus = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req", 64'(b0.mem_req), 64'd0);
        check_eq("rst_bus_valid", 64'(b0.bus_valid), 64'd0);
        check_eq("rst_bus_ready", 64'(b0.bus_ready), 64'd0);
        check_eq("rst_inval", 64'(b0.inval), 64'd0);
        check_eq("rst_dfb", 64'(|b0.data_from_bus), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Fill 0x1234, zero-wait grant, 1-cycle return
        rd_base = 64'hA000; gnt_mode = 0; lat = 1; bv0 = bv_cnt; rd0 = rd_log.size();
        b0.command_valid = 1'b1; b0.command_store = 1'b0; b0.command_rready = 1'b1;
        b0.command_addr = 64'h1234; a = cyc;
        wait_pulse(0, 100, at);
        b0.command_valid = 1'b0;
        check_eq("fill_latency", 64'(at - a), 64'd18);
        check_eq("fill_line", 64'(line_bad(b0.data_from_bus, 64'hA000)), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("fill_pulses", 64'(bv_cnt - bv0), 64'd1);
        check_eq("fill_nbeats", 64'(rd_log.size() - rd0), 64'd16);
        errs = 0;
        for (int k = 0; k < NW; k++)
            if (rd0 + k >= rd_log.size() || rd_log[rd0 + k] !== 64'h1230 + 64'(k)) errs++;
        check_eq("fill_addrs", 64'(errs), 64'd0);

        // Writeback 0x40 with toggling grant
        gnt_mode = 1; br0 = br_cnt; inv0 = inv_cnt; wr0 = wr_addr_log.size(); h0 = hold_err;
        b0.data_to_bus = mk_line(64'd0); b0.command_store = 1'b1;
        b0.command_addr = 64'h40; b0.command_valid = 1'b1;
        wait_pulse(1, 200, at);
        check_eq("wb_inval", 64'(b0.inval), 64'd1);
        check_eq("wb_inval_addr", b0.inval_addr, 64'h40);
        b0.command_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("wb_ready_pulses", 64'(br_cnt - br0), 64'd1);
        check_eq("wb_inval_pulses", 64'(inv_cnt - inv0), 64'd1);
        check_eq("wb_nbeats", 64'(wr_addr_log.size() - wr0), 64'd16);
        errs = 0;
        for (int k = 0; k < NW; k++)
            if (wr0 + k >= wr_addr_log.size() || wr_addr_log[wr0 + k] !== 64'h40 + 64'(k) ||
                wr_data_log[wr0 + k] !== 64'(k)) errs++;
        check_eq("wb_beats", 64'(errs), 64'd0);
        check_eq("wb_hold", 64'(hold_err - h0), 64'd0);

        // Back-to-back fill 0x100 then store 0x200
        gnt_mode = 0; rd_base = 64'hB000; bv0 = bv_cnt; br0 = br_cnt; wr0 = wr_addr_log.size();
        b0.command_store = 1'b0; b0.command_addr = 64'h100; b0.command_valid = 1'b1;
        wait_pulse(0, 100, at);
        b0.command_store = 1'b1; b0.command_addr = 64'h200; b0.data_to_bus = mk_line(64'h2000);
        repeat (2) @(negedge clk);
        check_eq("b2b_req_we", 64'({b0.mem_req, b0.mem_we}), 64'd3);
        check_eq("b2b_addr", b0.mem_addr, 64'h200);
        wait_pulse(1, 100, at);
        b0.command_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("b2b_valid_pulses", 64'(bv_cnt - bv0), 64'd1);
        check_eq("b2b_ready_pulses", 64'(br_cnt - br0), 64'd1);
        check_eq("b2b_line", 64'(line_bad(b0.data_from_bus, 64'hB000)), 64'd0);
        errs = 0;
        for (int k = 0; k < NW; k++)
            if (wr0 + k >= wr_addr_log.size() || wr_addr_log[wr0 + k] !== 64'h200 + 64'(k) ||
                wr_data_log[wr0 + k] !== 64'h2000 + 64'(k)) errs++;
        check_eq("b2b_wr_beats", 64'(errs), 64'd0);

        // Fill 0x500 with returns lagging five cycles behind grants
        lat = 5; rd_base = 64'hD000; bv0 = bv_cnt;
        b0.command_store = 1'b0; b0.command_addr = 64'h500; b0.command_valid = 1'b1; a = cyc;
        wait_pulse(0, 100, at);
        b0.command_valid = 1'b0;
        check_eq("lag_latency", 64'(at - a), 64'd22);
        check_eq("lag_line", 64'(line_bad(b0.data_from_bus, 64'hD000)), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("lag_pulses", 64'(bv_cnt - bv0), 64'd1);

        // Reset partway through a fill of 0x600
        lat = 3; rd_base = 64'hE000; bv0 = bv_cnt;
        b0.command_addr = 64'h600; b0.command_valid = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1; b0.command_valid = 1'b0;
        @(negedge clk);
        check_eq("rst2_mem_req", 64'(b0.mem_req), 64'd0);
        check_eq("rst2_mem_addr", b0.mem_addr, 64'd0);
        check_eq("rst2_dfb", 64'(|b0.data_from_bus), 64'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("rst2_no_pulse", 64'(bv_cnt - bv0), 64'd0);
        lat = 1; rd_base = 64'hC000; rd0 = rd_log.size();
        b0.command_addr = 64'h300; b0.command_valid = 1'b1; a = cyc;
        wait_pulse(0, 100, at);
        b0.command_valid = 1'b0;
        check_eq("post_rst_latency", 64'(at - a), 64'd18);
        check_eq("post_rst_line", 64'(line_bad(b0.data_from_bus, 64'hC000)), 64'd0);
        check_eq("post_rst_first_addr", (rd0 < rd_log.size()) ? rd_log[rd0] : 64'hDEAD, 64'h300);

        // Instance without store invalidate
        b1.data_to_bus = mk_line(64'h80); b1.command_store = 1'b1;
        b1.command_addr = 64'h80; b1.command_valid = 1'b1; a = cyc;
        wait_pulse(3, 100, at);
        b1.command_valid = 1'b0;
        check_eq("ni_wb_latency", 64'(at - a), 64'd17);
        check_eq("ni_inval", 64'(b1.inval), 64'd0);
        b1.command_store = 1'b0; b1.command_addr = 64'h90; b1.command_rready = 1'b0;
        b1.command_valid = 1'b1; errs = 0;
        repeat (3) begin
            @(negedge clk);
            if (b1.mem_req) errs++;
        end
        check_eq("ni_no_req_wo_rready", 64'(errs), 64'd0);
        b1.command_rready = 1'b1; a = cyc;
        wait_pulse(2, 100, at);
        b1.command_valid = 1'b0;
        check_eq("ni_fill_latency", 64'(at - a), 64'd18);
        check_eq("ni_fill_line", 64'(line_bad(b1.data_from_bus, 64'hF000)), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("ni_inval_pulses", 64'(ni_inv_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
